// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_pkg                                                      |
// | Description : Shared encodings for the MEM-stage data-bus access unit.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// +----------------------------------------------------------------------------+
// | Module      : load_align                                                   |
// | Description : Extracts the addressed lane of a bus word and extends it.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        result = w_shifted;
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: result = is_unsigned ? {16'b0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: result = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : MEM-stage load/store unit driving a req/ack data bus.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemSize,
    input  logic        MEM_MemUnsigned,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_WriteData,
    output logic [31:0] MEM_MemReadData,
    output logic        mem_stall,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    mem_state_t         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [1:0]         r_off;
    logic [1:0]         r_size;
    logic               r_uns;

    logic               w_access;
    logic               w_misalign;
    logic               w_is_byte;
    logic               w_is_half;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic [31:0]        w_load;

    assign w_access  = MEM_MemRead | MEM_MemWrite;
    assign w_is_byte = (MEM_MemSize == SZ_BYTE);
    assign w_is_half = (MEM_MemSize == SZ_HALF);
    // Size 2'b11 falls through to the word rules.
    assign w_misalign = w_is_half ? MEM_ALUout[0]
                      : (!w_is_byte && (MEM_ALUout[1:0] != 2'b00));

    always_comb begin
        w_wdata = MEM_WriteData;
        w_be    = 4'b1111;
        if (MEM_MemWrite) begin
            if (w_is_byte) begin
                w_wdata = {4{MEM_WriteData[7:0]}};
                w_be    = 4'b0001 << MEM_ALUout[1:0];
            end else if (w_is_half) begin
                w_wdata = {2{MEM_WriteData[15:0]}};
                w_be    = MEM_ALUout[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    load_align u_load_align (
        .rdata       (dbus_rdata),
        .addr_lo     (r_off),
        .size        (r_size),
        .is_unsigned (r_uns),
        .result      (w_load)
    );

    assign mem_stall       = !reset && (((r_state == ST_IDLE) && w_access && !w_misalign)
                                        || (r_state == ST_WAIT));
    assign misalign_exc    = !reset && (r_state == ST_IDLE) && w_access && w_misalign;
    assign bus_err         = !reset && (r_state == ST_DONE) && r_err;
    assign MEM_MemReadData = (r_state == ST_DONE) ? r_rdata : 32'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_off      <= '0;
            r_size     <= '0;
            r_uns      <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access && !w_misalign) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= MEM_MemWrite;
                        dbus_addr  <= {MEM_ALUout[31:2], 2'b00};
                        dbus_wdata <= w_wdata;
                        dbus_be    <= w_be;
                        r_off      <= MEM_ALUout[1:0];
                        r_size     <= MEM_MemSize;
                        r_uns      <= MEM_MemUnsigned;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count + 1'b1;
                    // An ack in the final wait cycle still completes normally.
                    if (dbus_ack) begin
                        r_rdata  <= w_load;
                        dbus_req <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (r_count == c_last) begin
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        dbus_req <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                           |
// | Description : Directed self-checking bench for mem_access_unit.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemUnsigned;
    logic [1:0]  MEM_MemSize;
    logic [31:0] MEM_ALUout, MEM_WriteData, MEM_MemReadData;
    logic        mem_stall, misalign_exc, bus_err;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_access
    int          st_cnt, mis_cnt, err_cnt;
    logic        req_seen, done_seen, early_data, err_at_done, req_at_done;
    logic [31:0] done_data, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .MEM_MemRead     (MEM_MemRead),
        .MEM_MemWrite    (MEM_MemWrite),
        .MEM_MemSize     (MEM_MemSize),
        .MEM_MemUnsigned (MEM_MemUnsigned),
        .MEM_ALUout      (MEM_ALUout),
        .MEM_WriteData   (MEM_WriteData),
        .MEM_MemReadData (MEM_MemReadData),
        .mem_stall       (mem_stall),
        .misalign_exc    (misalign_exc),
        .bus_err         (bus_err),
        .dbus_req        (dbus_req),
        .dbus_we         (dbus_we),
        .dbus_addr       (dbus_addr),
        .dbus_wdata      (dbus_wdata),
        .dbus_be         (dbus_be),
        .dbus_ack        (dbus_ack),
        .dbus_rdata      (dbus_rdata)
    );

    // Presents one access and holds it until the first non-stalled cycle.
    // ack_at = k pulses dbus_ack in cycle Ck (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rdat, input int ack_at);
        st_cnt = 0; mis_cnt = 0; err_cnt = 0;
        req_seen = 0; done_seen = 0; early_data = 0; err_at_done = 0; req_at_done = 0;
        done_data = 32'hx; cap_addr = 32'hx; cap_wdata = 32'hx; cap_be = 4'hx; cap_we = 1'bx;
        @(posedge clk); #1;
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemSize = sz; MEM_MemUnsigned = uns;
        MEM_ALUout = a; MEM_WriteData = d; dbus_rdata = rdat;
        for (int c = 0; c < 40; c++) begin
            dbus_ack = (ack_at > 0) && (c == ack_at);
            @(negedge clk);
            if (mem_stall) st_cnt++;
            if (misalign_exc) mis_cnt++;
            if (bus_err) err_cnt++;
            if (dbus_req && !req_seen) begin
                req_seen = 1; cap_addr = dbus_addr; cap_wdata = dbus_wdata;
                cap_be = dbus_be; cap_we = dbus_we;
            end
            if (!mem_stall) begin
                done_seen = 1; done_data = MEM_MemReadData;
                err_at_done = bus_err; req_at_done = dbus_req;
                break;
            end
            if (MEM_MemReadData !== 32'h0) early_data = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (!done_seen) begin
            errors++; $display("FAIL access_complete: stall never released after %0d cycles", st_cnt);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MEM_MemRead = 0; MEM_MemWrite = 0; MEM_MemSize = 2'b00; MEM_MemUnsigned = 0;
        MEM_ALUout = 32'h0; MEM_WriteData = 32'h0; dbus_ack = 0;
    endtask

    task automatic test_reset();
        reset = 1; dbus_ack = 0; dbus_rdata = 32'h0;
        MEM_MemRead = 1; MEM_MemWrite = 0; MEM_MemSize = 2'b00; MEM_MemUnsigned = 0;
        MEM_ALUout = 32'h100; MEM_WriteData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dbus_req); end
        checks++; if (dbus_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %b expected 0000", dbus_be); end
        checks++; if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || dbus_we !== 1'b0) begin
            errors++; $display("FAIL reset_bus: addr %h wdata %h we %b expected all 0", dbus_addr, dbus_wdata, dbus_we);
        end
        checks++; if (MEM_MemReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", MEM_MemReadData); end
        @(posedge clk); #1;
        MEM_MemRead = 0; reset = 0;
    endtask

    task automatic test_lw();
        run_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        checks++; if (st_cnt != 2) begin errors++; $display("FAIL lw_stall: got %0d expected 2", st_cnt); end
        checks++; if (cap_addr !== 32'h100 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
            errors++; $display("FAIL lw_bus: addr %h be %b we %b expected 00000100 1111 0", cap_addr, cap_be, cap_we);
        end
        checks++; if (done_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", done_data); end
        checks++; if (early_data) begin errors++; $display("FAIL lw_data_early: nonzero read data before DONE, expected 0"); end
        checks++; if (req_at_done !== 1'b0) begin errors++; $display("FAIL lw_req_done: got %b expected 0", req_at_done); end
        go_idle();
        @(negedge clk);
        checks++; if (MEM_MemReadData !== 32'h0) begin errors++; $display("FAIL lw_data_after: got %h expected 0", MEM_MemReadData); end
    endtask

    task automatic test_loads();
        run_access(1, 0, 2'b10, 0, 32'h103, 32'h0, 32'h80112233, 1);
        checks++; if (done_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h expected ffffff80", done_data); end
        go_idle();
        run_access(1, 0, 2'b10, 1, 32'h103, 32'h0, 32'h80112233, 1);
        checks++; if (done_data !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", done_data); end
        go_idle();
        run_access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80112233, 1);
        checks++; if (done_data !== 32'hFFFF8011) begin errors++; $display("FAIL lh: got %h expected ffff8011", done_data); end
        go_idle();
        run_access(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80112233, 1);
        checks++; if (done_data !== 32'h00008011) begin errors++; $display("FAIL lhu: got %h expected 00008011", done_data); end
        go_idle();
        run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h80112233, 2);
        checks++; if (done_data !== 32'h00000022) begin errors++; $display("FAIL lb_lane1: got %h expected 00000022", done_data); end
        checks++; if (st_cnt != 3) begin errors++; $display("FAIL lb_lane1_stall: got %0d expected 3", st_cnt); end
        go_idle();
    endtask

    task automatic test_stores();
        run_access(0, 1, 2'b10, 0, 32'h101, 32'h000000A5, 32'h0, 1);
        checks++; if (cap_be !== 4'b0010 || cap_wdata !== 32'hA5A5A5A5 || cap_we !== 1'b1 || cap_addr !== 32'h100) begin
            errors++; $display("FAIL sb: be %b wdata %h we %b addr %h expected 0010 a5a5a5a5 1 00000100", cap_be, cap_wdata, cap_we, cap_addr);
        end
        go_idle();
        run_access(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 32'h0, 1);
        checks++; if (cap_be !== 4'b1100 || cap_wdata !== 32'h12341234 || cap_we !== 1'b1 || cap_addr !== 32'h100) begin
            errors++; $display("FAIL sh: be %b wdata %h we %b addr %h expected 1100 12341234 1 00000100", cap_be, cap_wdata, cap_we, cap_addr);
        end
        go_idle();
        run_access(0, 1, 2'b00, 0, 32'h204, 32'hCAFEF00D, 32'h0, 3);
        checks++; if (cap_be !== 4'b1111 || cap_wdata !== 32'hCAFEF00D || cap_addr !== 32'h204) begin
            errors++; $display("FAIL sw: be %b wdata %h addr %h expected 1111 cafef00d 00000204", cap_be, cap_wdata, cap_addr);
        end
        checks++; if (st_cnt != 4) begin errors++; $display("FAIL sw_stall: got %0d expected 4", st_cnt); end
        go_idle();
    endtask

    task automatic test_misaligned();
        run_access(1, 0, 2'b00, 0, 32'h102, 32'h0, 32'h12345678, 0);
        checks++; if (mis_cnt != 1 || req_seen || st_cnt != 0 || done_data !== 32'h0) begin
            errors++; $display("FAIL lw_misalign: exc %0d req %b stall %0d data %h expected 1 0 0 0", mis_cnt, req_seen, st_cnt, done_data);
        end
        go_idle();
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0 || misalign_exc !== 1'b0) begin
            errors++; $display("FAIL lw_misalign_after: req %b exc %b expected 0 0", dbus_req, misalign_exc);
        end
        run_access(0, 1, 2'b01, 0, 32'h101, 32'h0000BEEF, 32'h0, 0);
        checks++; if (mis_cnt != 1 || req_seen || st_cnt != 0) begin
            errors++; $display("FAIL sh_misalign: exc %0d req %b stall %0d expected 1 0 0", mis_cnt, req_seen, st_cnt);
        end
        go_idle();
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0 || dbus_wdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL sh_misalign_dropped: req %b wdata %h expected 0 cafef00d", dbus_req, dbus_wdata);
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 2'b00, 0, 32'h300, 32'h0, 32'h55AA55AA, 0);
        checks++; if (st_cnt != 5) begin errors++; $display("FAIL timeout_stall: got %0d expected 5", st_cnt); end
        checks++; if (err_cnt != 1 || err_at_done !== 1'b1) begin
            errors++; $display("FAIL timeout_err: pulses %0d at_done %b expected 1 1", err_cnt, err_at_done);
        end
        checks++; if (done_data !== 32'h0 || req_at_done !== 1'b0) begin
            errors++; $display("FAIL timeout_done: data %h req %b expected 0 0", done_data, req_at_done);
        end
        go_idle();
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b expected 0", bus_err); end
    endtask

    task automatic test_back_to_back();
        run_access(1, 0, 2'b00, 0, 32'h104, 32'h0, 32'h11223344, 1);
        checks++; if (done_data !== 32'h11223344) begin errors++; $display("FAIL b2b_load: got %h expected 11223344", done_data); end
        // Read+write together with size 11: a word write.
        run_access(1, 1, 2'b11, 0, 32'h108, 32'h55667788, 32'h0, 2);
        checks++; if (st_cnt != 3 || cap_we !== 1'b1 || cap_be !== 4'b1111 || cap_wdata !== 32'h55667788 || cap_addr !== 32'h108) begin
            errors++; $display("FAIL b2b_store: stall %0d we %b be %b wdata %h addr %h expected 3 1 1111 55667788 00000108",
                               st_cnt, cap_we, cap_be, cap_wdata, cap_addr);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        MEM_MemRead = 1; MEM_MemSize = 2'b00; MEM_ALUout = 32'h100; dbus_ack = 0; dbus_rdata = 32'hA1B2C3D4;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_wait_stall: got %b expected 0", mem_stall); end
        @(posedge clk); #1;
        reset = 0; MEM_MemRead = 0; MEM_ALUout = 32'h0; dbus_ack = 1;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rst_wait_req: req %b stall %b expected 0 0", dbus_req, mem_stall);
        end
        @(posedge clk); #1;
        dbus_ack = 0;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0 || MEM_MemReadData !== 32'h0 || bus_err !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rst_late_ack: req %b data %h err %b stall %b expected 0 0 0 0",
                               dbus_req, MEM_MemReadData, bus_err, mem_stall);
        end
        run_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hA1B2C3D4, 1);
        checks++; if (st_cnt != 2 || done_data !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL rst_recover: stall %0d data %h expected 2 a1b2c3d4", st_cnt, done_data);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

- Sits in the MEM stage, directly upstream of the MEM/WB pipeline register.
- Turns the stage's load/store control and ALU address into transactions on a req/ack data bus, stalling the pipeline until the bus acknowledges.
- Handles byte, halfword and word stores with lane steering and byte enables; loads get lane extraction and sign or zero extension.
- Drives `MEM_MemReadData` into the MEM/WB register and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait cycles without `dbus_ack` before the access is abandoned with `bus_err`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `MEM_MemRead`  in  1  load in MEM stage.
- `MEM_MemWrite`  in  1  store in MEM stage.
- `MEM_MemSize`  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- `MEM_MemUnsigned`  in  1  zero-extend loads (lbu/lhu).
- `MEM_ALUout`  in  32  effective byte address.
- `MEM_WriteData`  in  32  store data, right-justified.
- `MEM_MemReadData`  out  32  formatted load data to MEM/WB.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB is loaded with a bubble.
- `misalign_exc`  out  1  misaligned access, one-cycle pulse.
- `bus_err`  out  1  timeout, one-cycle pulse.
- `dbus_req`  out  1  bus request, registered.
- `dbus_we`  out  1  write, registered.
- `dbus_addr`  out  32  word address, `{addr[31:2],2'b00}`, registered.
- `dbus_wdata`  out  32  lane-steered store data, registered.
- `dbus_be`  out  4  byte enables; bit i = byte lane i (little-endian), registered.
- `dbus_ack`  in  1  transaction complete, single-cycle pulse.
- `dbus_rdata`  in  32  read data, valid in the `dbus_ack` cycle.

## Operation
- **Access**: `MEM_MemRead | MEM_MemWrite`. If both are high, it is a write and the read is ignored.
- **Misaligned**: word with `addr[1:0]≠0`; half with `addr[0]=1`. No bus request; `misalign_exc=1`; `mem_stall=0`; read data 0; the store is dropped.
- **Store steering**:
  - sb: `be=4'b0001<<addr[1:0]`, `wdata={4{d[7:0]}}`.
  - sh: `be=addr[1]?1100:0011`, `wdata={2{d[15:0]}}`.
  - sw: `be=1111`, `wdata=d`.
- **Loads**: `be=1111`. The selected lane is `dbus_rdata>>(8*addr[1:0])`, truncated to size, then sign-extended unless `MEM_MemUnsigned`.
- **FSM states**: IDLE, WAIT, DONE.
  - IDLE, aligned access: `mem_stall=1`; load bus registers; `dbus_req←1`; go to WAIT. Otherwise stay in IDLE.
  - WAIT: `mem_stall=1`; count++.
    - `dbus_ack`: capture formatted data into `rdata_q`; `dbus_req←0`; go to DONE.
    - count reaches `TIMEOUT_CYCLES`: `dbus_req←0`; set error flag; `rdata_q←0`; go to DONE.
  - DONE: `mem_stall=0`; `MEM_MemReadData=rdata_q`; `bus_err`=error flag; go to IDLE (flag cleared, count cleared).
- `MEM_MemReadData=0` in every state except DONE.
- Bus outputs other than `dbus_req` hold their values until the next access.

## Timing
- **Stall length**: access in cycle C0; `dbus_req` high from C1. If ack arrives in cycle Ck (k≥1), DONE is in Ck+1. Stall is asserted for C0..Ck, so minimum 2 cycles.
- **Pipeline advance**: the pipeline advances at the end of the DONE cycle; MEM/WB captures `MEM_MemReadData` at that edge.
- **Back-to-back**: a new access entering MEM after DONE starts in IDLE the next cycle. No idle gap is needed beyond DONE.
- **Stall / pulse logic**: `mem_stall`, `misalign_exc` and `bus_err` are combinational from state and inputs.
- **Reset values**: while `reset` is high, `mem_stall`, `misalign_exc` and `bus_err` are forced to 0. At a reset edge:
  - state IDLE; count 0; `rdata_q` 0.
  - all bus outputs 0, including `dbus_req` and `dbus_be`.
  - `MEM_MemReadData` 0.
- **Reset mid-WAIT**: drops `dbus_req` at that edge. A late `dbus_ack` in IDLE is ignored.
- **Ack outside WAIT**: ignored in IDLE and DONE.
- **Timeout bound**: `TIMEOUT_CYCLES`=N gives at most N+1 stall cycles before DONE.

## Structure
- `mem_pkg` holds:
  - size encodings `SZ_WORD=2'b00`, `SZ_HALF=2'b01`, `SZ_BYTE=2'b10`;
  - the state encoding IDLE/WAIT/DONE;
  - the `TIMEOUT_CYCLES` default.
- Sub-module `load_align`, purely combinational, takes `(rdata, addr[1:0], size, unsigned)` and returns the 32-bit result. It is reused by the test model.
- Store steering stays inline in the top level.

## Test plan
- **lw**: addr 0x100, ack in 1st WAIT cycle, rdata 0xDEADBEEF. Expect:
  - `mem_stall` high exactly 2 cycles;
  - `dbus_addr=0x100`, `be=1111`;
  - `MEM_MemReadData=0xDEADBEEF` in DONE only.
- **lb / lbu**: addr 0x103, rdata 0x80112233. Expect `lb`→0xFFFFFF80 and `lbu`→0x00000080. `lh` at 0x102→0xFFFF8011.
- **sb / sh**: `sb` addr 0x101, data 0x000000A5 → `be=0010`, `wdata=0xA5A5A5A5`, `we=1`. `sh` addr 0x102, data 0x1234 → `be=1100`, `wdata=0x12341234`.
- **Misaligned**: `lw` addr 0x102 → `misalign_exc` for 1 cycle, `dbus_req` never rises, `mem_stall=0`. `sh` addr 0x101 → same.
- **Timeout**: `TIMEOUT_CYCLES=4`, no ack → `dbus_req` drops, `bus_err` 1-cycle pulse in DONE, `MEM_MemReadData=0`, total stall 5 cycles.
- **Reset mid-WAIT**: `reset` high at the 3rd WAIT cycle → next cycle `dbus_req=0`, `mem_stall=0`, state IDLE. A late `dbus_ack` has no effect.
